// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit scheduler.
//   - MDU op-code constants as presented on mdu_op / d_mdu_op
//   - FSM state encoding used by mdu_sched
//   - helper that classifies ops occupying the multi-cycle datapath
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // True for ops that hold the unit busy for several cycles.
    function automatic logic is_long_op(input logic [3:0] op, input logic madd_en);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU)  ||
               (madd_en && (op == MDU_MADD));
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational arithmetic for the MDU.
//   a, b       : 32-bit operands (rs, rt)
//   op_signed  : 1 = signed multiply/divide, 0 = unsigned
//   prod       : 64-bit product {hi, lo}
//   quot, rem  : quotient / remainder; signed quotient truncates toward
//                zero, remainder carries the sign of the dividend
//   div_zero   : divisor is zero (quot/rem are then meaningless)
module mdu_arith (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op_signed,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_safe_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;

    assign prod_signed_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_unsigned_s = {32'd0, a} * {32'd0, b};

    // Product select.
    always_comb begin
        if (op_signed) begin
            prod = prod_signed_s;
        end else begin
            prod = prod_unsigned_s;
        end
    end

    // Signed divide runs on magnitudes through one unsigned divider.
    // 0x80000000 / -1 falls out naturally: |a| = 0x80000000, q = 0x80000000,
    // and equal signs leave it un-negated.
    always_comb begin
        a_neg_s  = op_signed & a[31];
        b_neg_s  = op_signed & b[31];
        div_zero = (b == 32'd0);
        if (a_neg_s) begin
            a_mag_s = 32'd0 - a;
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = 32'd0 - b;
        end else begin
            b_mag_s = b;
        end
        // A zero divisor is replaced so the divider never sees it.
        if (div_zero) begin
            b_safe_s = 32'd1;
        end else begin
            b_safe_s = b_mag_s;
        end
        q_mag_s = a_mag_s / b_safe_s;
        r_mag_s = a_mag_s % b_safe_s;
        if (a_neg_s ^ b_neg_s) begin
            quot = 32'd0 - q_mag_s;
        end else begin
            quot = q_mag_s;
        end
        if (a_neg_s) begin
            rem = 32'd0 - r_mag_s;
        end else begin
            rem = r_mag_s;
        end
    end

endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: multiply/divide unit scheduler with HI/LO and D-stage stall.
//   clk, reset     : clock, synchronous active-high reset
//   start, mdu_op  : E-stage MDU op and its code
//   rs_val, rt_val : forwarded operands
//   exc_flush      : E-stage instruction cancelled
//   d_mdu_op       : D-stage MDU op (stall generation)
//   busy           : a mult/div is in flight
//   stall          : freeze D stage
//   hi, lo         : architectural HI/LO
//   rd_data        : mfhi/mflo read data (combinational on mdu_op)
// Optional feature: define MDU_MADD_EN to execute op 9 as signed
// multiply-accumulate into {HI,LO}; otherwise op 9 is a no-op.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        exc_flush,
    input  logic [3:0]  d_mdu_op,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

`ifdef MDU_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    mdu_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [31:0]      hi_r, hi_s;
    logic [31:0]      lo_r, lo_s;
    logic [31:0]      res_hi_r, res_hi_s;
    logic [31:0]      res_lo_r, res_lo_s;
    logic             res_wr_r, res_wr_s;
    logic             busy_r, busy_s;

    logic             launch_s;
    logic             op_signed_s;
    logic             madd_op_s;
    logic [63:0]      madd_sum_s;
    logic [63:0]      prod_s;
    logic [31:0]      quot_s;
    logic [31:0]      rem_s;
    logic             div_zero_s;

    assign launch_s    = start && !exc_flush && (state_r == ST_IDLE);
    assign op_signed_s = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV) || (mdu_op == MDU_MADD);

    mdu_arith u_arith (
        .a         (rs_val),
        .b         (rt_val),
        .op_signed (op_signed_s),
        .prod      (prod_s),
        .quot      (quot_s),
        .rem       (rem_s),
        .div_zero  (div_zero_s)
    );

`ifdef MDU_MADD_EN
    // Accumulate uses HI/LO as they stand at launch.
    assign madd_op_s  = (mdu_op == MDU_MADD);
    assign madd_sum_s = {hi_r, lo_r} + prod_s;
`else
    assign madd_op_s  = 1'b0;
    assign madd_sum_s = 64'd0;
`endif

    // Next-state, counter and HI/LO update.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        res_hi_s = res_hi_r;
        res_lo_s = res_lo_r;
        res_wr_s = res_wr_r;
        busy_s   = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    case (mdu_op)
                        MDU_MULT, MDU_MULTU: begin
                            state_s  = ST_MUL;
                            cnt_s    = MULT_LOAD;
                            busy_s   = 1'b1;
                            res_hi_s = prod_s[63:32];
                            res_lo_s = prod_s[31:0];
                            res_wr_s = 1'b1;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            state_s  = ST_DIV;
                            cnt_s    = DIV_LOAD;
                            busy_s   = 1'b1;
                            res_hi_s = rem_s;
                            res_lo_s = quot_s;
                            // Divide-by-zero still takes full latency but leaves HI/LO alone.
                            res_wr_s = !div_zero_s;
                        end
                        MDU_MTHI: hi_s = rs_val;
                        MDU_MTLO: lo_s = rs_val;
                        MDU_MADD: begin
                            if (madd_op_s) begin
                                state_s  = ST_MUL;
                                cnt_s    = MULT_LOAD;
                                busy_s   = 1'b1;
                                res_hi_s = madd_sum_s[63:32];
                                res_lo_s = madd_sum_s[31:0];
                                res_wr_s = 1'b1;
                            end else begin
                                state_s = ST_IDLE;
                            end
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                // Counter holds N in the first busy cycle; commit when it reaches 1.
                if (cnt_r == CNT_ONE) begin
                    state_s  = ST_IDLE;
                    cnt_s    = CNT_ZERO;
                    busy_s   = 1'b0;
                    res_wr_s = 1'b0;
                    if (res_wr_r) begin
                        hi_s = res_hi_r;
                        lo_s = res_lo_r;
                    end else begin
                        hi_s = hi_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                cnt_s    = CNT_ZERO;
                busy_s   = 1'b0;
                res_wr_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            res_hi_r <= 32'd0;
            res_lo_r <= 32'd0;
            res_wr_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            res_hi_r <= res_hi_s;
            res_lo_r <= res_lo_s;
            res_wr_r <= res_wr_s;
            busy_r   <= busy_s;
        end
    end

    // Read mux for mfhi/mflo; registered HI/LO give pre-commit values.
    always_comb begin
        case (mdu_op)
            MDU_MFHI: rd_data = hi_r;
            MDU_MFLO: rd_data = lo_r;
            default:  rd_data = 32'd0;
        endcase
    end

    assign stall = (d_mdu_op != 4'd0) &&
                   (busy_r || (start && !exc_flush && is_long_op(mdu_op, MADD_EN)));
    assign busy  = busy_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        exc_flush;
    logic [3:0]  d_mdu_op;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    bit          rst_edge;
    int          busy_run;

    mdu_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mdu_op    (mdu_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .exc_flush (exc_flush),
        .d_mdu_op  (d_mdu_op),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo),
        .rd_data   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) rst_edge = reset;

    // Commit monitor: pops the expected result when busy falls.
    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) begin
            busy_run = 0;
        end else if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run > 0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_empty: commit with no expected entry, hi=%h lo=%h", hi, lo);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (busy_run !== e.cyc) $display("FAIL sb_latency: got %0d want %0d", busy_run, e.cyc);
                else n_pass++;
                n_checks++;
                if (hi !== e.hi) $display("FAIL sb_hi: got %h want %h", hi, e.hi);
                else n_pass++;
                n_checks++;
                if (lo !== e.lo) $display("FAIL sb_lo: got %h want %h", lo, e.lo);
                else n_pass++;
            end
            busy_run = 0;
        end
    end

    task automatic model_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      rm;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] r;
        logic [63:0] r2;
        exp_t        e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e.hi = m_hi;
        e.lo = m_lo;
        e.cyc = MULT_N;
        case (op)
            MDU_MULT: begin
                r = sa * sb;
                e.hi = r[63:32]; e.lo = r[31:0];
                exp_q.push_back(e);
            end
            MDU_MULTU: begin
                r = ua * ub;
                e.hi = r[63:32]; e.lo = r[31:0];
                exp_q.push_back(e);
            end
            MDU_DIV: begin
                e.cyc = DIV_N;
                if (b != 32'd0) begin
                    q = sa / sb;
                    rm = sa % sb;
                    r = q; r2 = rm;
                    e.lo = r[31:0]; e.hi = r2[31:0];
                end
                exp_q.push_back(e);
            end
            MDU_DIVU: begin
                e.cyc = DIV_N;
                if (b != 32'd0) begin
                    r = ua / ub; r2 = ua % ub;
                    e.lo = r[31:0]; e.hi = r2[31:0];
                end
                exp_q.push_back(e);
            end
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                r2 = sa * sb;
                r = {m_hi, m_lo} + r2;
                e.hi = r[63:32]; e.lo = r[31:0];
                exp_q.push_back(e);
            end
`endif
            MDU_MTHI: e.hi = a;
            MDU_MTLO: e.lo = a;
            default: e.hi = m_hi;
        endcase
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    // Drive one op for one cycle; returns at the negedge after the launch edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic flush, input bit track);
        start = 1'b1; mdu_op = op; rs_val = a; rt_val = b; exc_flush = flush;
        if (track && !flush) model_step(op, a, b);
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0; exc_flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b after %0d cycles", busy, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
        exc_flush = 1'b0; d_mdu_op = 4'd0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL rst_hi: got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL rst_lo: got %h want 0", lo); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall_idle: got %b want 0", stall); else n_pass++;
        start = 1'b1; mdu_op = MDU_MULT; d_mdu_op = MDU_MFLO;
        #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL rst_stall_inputs: got %b want 1", stall); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_no_launch: got %b want 0", busy); else n_pass++;
        start = 1'b0; mdu_op = 4'd0; d_mdu_op = 4'd0; reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_mult();
        issue(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
        n_checks++; if (busy !== 1'b1) $display("FAIL mult_busy: got %b want 1", busy); else n_pass++;
        wait_idle();
        n_checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want FFFFFFFF", hi); else n_pass++;
        n_checks++; if (lo !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h want FFFFFFFA", lo); else n_pass++;
        issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
        wait_idle();
        n_checks++; if (hi !== 32'h00000002) $display("FAIL multu_hi: got %h want 00000002", hi); else n_pass++;
        n_checks++; if (lo !== 32'hFFFFFFFA) $display("FAIL multu_lo: got %h want FFFFFFFA", lo); else n_pass++;
    endtask

    task automatic test_div();
        issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
        wait_idle();
        n_checks++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h want FFFFFFFD", lo); else n_pass++;
        n_checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h want FFFFFFFF", hi); else n_pass++;
        issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_idle();
        n_checks++; if (lo !== 32'h80000000) $display("FAIL div_ovf_lo: got %h want 80000000", lo); else n_pass++;
        n_checks++; if (hi !== 32'h00000000) $display("FAIL div_ovf_hi: got %h want 00000000", hi); else n_pass++;
        issue(MDU_DIVU, 32'd7, 32'd0, 1'b0, 1'b1);
        wait_idle();
        n_checks++; if (lo !== 32'h80000000) $display("FAIL divu_zero_lo: got %h want 80000000", lo); else n_pass++;
        n_checks++; if (hi !== 32'h00000000) $display("FAIL divu_zero_hi: got %h want 00000000", hi); else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : $urandom;
            if (i % 2 == 1) b = b & 32'h0000FFFF;
            issue(op, a, b, 1'b0, 1'b1);
            wait_idle();
        end
    endtask

    task automatic test_back_to_back();
        issue(MDU_MULTU, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
        wait_idle();
        issue(MDU_DIV, 32'h7FFFFFFF, 32'hFFFFFFF0, 1'b0, 1'b1);
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else n_pass++;
        wait_idle();
    endtask

    task automatic test_stall_mflo();
        logic [31:0] old_lo;
        old_lo = m_lo;
        issue(MDU_MULT, 32'h00010001, 32'h00010003, 1'b0, 1'b1);
        d_mdu_op = MDU_MFLO;
        for (int k = 1; k <= MULT_N; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 2) begin
                start = 1'b1; mdu_op = MDU_MULT; rs_val = 32'd9; rt_val = 32'd9;
            end
            if (k == 3) begin
                start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
            end
            if (k == MULT_N) begin
                start = 1'b1; mdu_op = MDU_MFLO;
            end
            #1;
            n_checks++; if (stall !== 1'b1) $display("FAIL stall_busy_c%0d: got %b want 1", k, stall); else n_pass++;
            if (k == MULT_N) begin
                n_checks++;
                if (rd_data !== old_lo) $display("FAIL mflo_precommit: got %h want %h", rd_data, old_lo);
                else n_pass++;
            end
        end
        @(negedge clk);
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL stall_after: got %b want 0", stall); else n_pass++;
        n_checks++; if (rd_data !== m_lo) $display("FAIL mflo_new: got %h want %h", rd_data, m_lo); else n_pass++;
        start = 1'b0; mdu_op = 4'd0; d_mdu_op = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_mthi_flush();
        logic [31:0] old_hi;
        old_hi = m_hi;
        issue(MDU_MTHI, 32'h00001234, 32'd0, 1'b1, 1'b1);
        n_checks++; if (hi !== old_hi) $display("FAIL mthi_flush: got %h want %h", hi, old_hi); else n_pass++;
        issue(MDU_MTHI, 32'h00001234, 32'd0, 1'b0, 1'b1);
        n_checks++; if (hi !== 32'h00001234) $display("FAIL mthi: got %h want 00001234", hi); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", busy); else n_pass++;
        issue(MDU_MTLO, 32'hCAFE0001, 32'd0, 1'b0, 1'b1);
        n_checks++; if (lo !== 32'hCAFE0001) $display("FAIL mtlo: got %h want CAFE0001", lo); else n_pass++;
        start = 1'b1; mdu_op = MDU_DIV; exc_flush = 1'b1; d_mdu_op = MDU_MFHI;
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL stall_flush: got %b want 0", stall); else n_pass++;
        exc_flush = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL stall_e_long: got %b want 1", stall); else n_pass++;
        start = 1'b0; mdu_op = 4'd0; d_mdu_op = 4'd0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL no_launch: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_div();
        issue(MDU_MTHI, 32'hAAAA5555, 32'd0, 1'b0, 1'b1);
        issue(MDU_MTLO, 32'h5555AAAA, 32'd0, 1'b0, 1'b1);
        issue(MDU_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (hi !== 32'd0) $display("FAIL rstdiv_hi: got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL rstdiv_lo: got %h want 0", lo); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstdiv_busy: got %b want 0", busy); else n_pass++;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (DIV_N + 2) @(negedge clk);
        n_checks++; if (hi !== 32'd0) $display("FAIL rstdiv_hi_late: got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL rstdiv_lo_late: got %h want 0", lo); else n_pass++;
    endtask

    task automatic test_madd();
`ifdef MDU_MADD_EN
        issue(MDU_MTHI, 32'd0, 32'd0, 1'b0, 1'b1);
        issue(MDU_MTLO, 32'd1, 32'd0, 1'b0, 1'b1);
        issue(MDU_MADD, 32'd2, 32'd3, 1'b0, 1'b1);
        n_checks++; if (busy !== 1'b1) $display("FAIL madd_busy: got %b want 1", busy); else n_pass++;
        wait_idle();
        n_checks++; if (lo !== 32'd7) $display("FAIL madd_lo: got %h want 7", lo); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL madd_hi: got %h want 0", hi); else n_pass++;
`else
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        start = 1'b1; mdu_op = MDU_MADD; rs_val = 32'd2; rt_val = 32'd3; d_mdu_op = MDU_MFLO;
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL madd_off_stall: got %b want 0", stall); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL madd_off_busy: got %b want 0", busy); else n_pass++;
        start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0; d_mdu_op = 4'd0;
        @(negedge clk);
        n_checks++; if (lo !== old_lo) $display("FAIL madd_off_lo: got %h want %h", lo, old_lo); else n_pass++;
        n_checks++; if (hi !== old_hi) $display("FAIL madd_off_hi: got %h want %h", hi, old_hi); else n_pass++;
`endif
    endtask

    initial begin
        busy_run = 0;
        rst_edge = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        reset = 1'b1; start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
        exc_flush = 1'b0; d_mdu_op = 4'd0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_random();
        test_back_to_back();
        test_stall_mflo();
        test_mthi_flush();
        test_reset_mid_div();
        test_madd();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
